// File: rtl/alu_serial.sv
// Bit-serial ALU: add / subtract / AND / OR through one 1-bit slice, LSB first.
// Latency: command handshake at edge T -> result valid from edge T+WIDTH (seen at T+WIDTH+1).
// Backpressure: one command in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      command handshake carrying a, b, opcode, cin
//   out_valid/out_ready    result handshake carrying result, cout, zero
module alu_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       opcode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;       // operand A, shifted right one bit per step
    logic [WIDTH-1:0]   b_q, b_d;       // operand B, shifted right one bit per step
    logic [1:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_q, acc_d;   // partial result, filled from the MSB end
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;

    // single-bit slice
    logic               bit_a, bit_b, bb;
    logic               r_bit, c_next;
    logic [WIDTH-1:0]   res_full;

    always_comb begin
        bit_a  = a_q[0];
        bit_b  = b_q[0];
        bb     = (op_q == OP_SUB) ? ~bit_b : bit_b;
        r_bit  = 1'b0;
        c_next = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                r_bit  = bit_a ^ bb ^ carry_q;
                c_next = (bit_a & bb) | (bit_a & carry_q) | (bb & carry_q);
            end
            OP_AND:  r_bit = bit_a & bit_b;
            default: r_bit = bit_a | bit_b;
        endcase
        // Shifting the new bit in at the top means that after WIDTH steps
        // bit 0 has landed back at index 0.
        res_full = {r_bit, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = opcode;
                    // Subtract is a + ~b + 1: the +1 enters as the initial carry.
                    carry_d = (opcode == OP_ADD) ? cin : (opcode == OP_SUB);
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = res_full;
                carry_d = c_next;
                if (cnt_q == LAST_BIT) begin
                    // counter parks at the last bit; it is cleared on the next command
                    result_d = res_full;
                    cout_d   = c_next;
                    zero_d   = ~|res_full;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign zero   = zero_q;

endmodule
